ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 125 ++++++++++++
 tb/tb_ram_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: three-way SDRAM access arbiter (download, video, CPU) with fixed or round-robin priority
//
// Ports:
//   F14M, RESET_n                     clock, asynchronous active-low reset
//   dio_req/addr/data -> dio_ack      download writes (highest priority)
//   vid_req/addr -> vid_data/vid_ack  video reads
//   cpu_req/we/addr/din -> cpu_dout/cpu_ack/cpu_wait_n  CPU reads and writes
//   ram_addr/ram_din/ram_we/ram_oe    registered command to the SDRAM controller
//   ram_dout                          SDRAM read data, valid RAM_LAT cycles after issue
//   grant                             current owner: 0 none, 1 dio, 2 vid, 3 cpu
//
// Build option: define ARB_ROUNDROBIN_EN to let vid and cpu alternate when both are pending.
module ram_arbiter #(
  parameter int ADDR_W  = 25,
  parameter int RAM_LAT = 3
) (
  input  logic              F14M,
  input  logic              RESET_n,
  input  logic              dio_req,
  input  logic [ADDR_W-1:0] dio_addr,
  input  logic [7:0]        dio_data,
  output logic              dio_ack,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [7:0]        vid_data,
  output logic              vid_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_ack,
  output logic              cpu_wait_n,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_we,
  output logic              ram_oe,
  input  logic [7:0]        ram_dout,
  output logic [1:0]        grant
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam logic [1:0] G_DIO = 2'd1;
  localparam logic [1:0] G_VID = 2'd2;
  localparam logic [1:0] G_CPU = 2'd3;
  // WAIT spans RAM_LAT-1 cycles, counting 0 .. RAM_LAT-2
  localparam logic [2:0] WAIT_LAST = 3'(RAM_LAT - 2);
  state_t            state_q;
  logic [2:0]        cnt_q;
  logic [1:0]        grant_q, grant_d;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [7:0]        ram_din_q, vid_data_q, cpu_dout_q;
  logic              ram_we_q, ram_oe_q, dio_ack_q, vid_ack_q, cpu_ack_q;
`ifdef ARB_ROUNDROBIN_EN
  // rr_q high: vid wins a vid/cpu tie; flips on every vid or cpu grant
  logic rr_q;
  always_comb grant_d = dio_req ? G_DIO : (vid_req && (rr_q || !cpu_req)) ? G_VID : cpu_req ? G_CPU : 2'd0;
  always_ff @(posedge F14M or negedge RESET_n)
    if (!RESET_n) rr_q <= 1'b1;
    else if (state_q == IDLE && grant_d[1]) rr_q <= ~rr_q;
`else
  always_comb grant_d = dio_req ? G_DIO : vid_req ? G_VID : cpu_req ? G_CPU : 2'd0;
`endif
  always_ff @(posedge F14M or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      grant_q    <= 2'd0;
      ram_addr_q <= '0;
      ram_din_q  <= 8'h00;
      ram_we_q   <= 1'b0;
      ram_oe_q   <= 1'b0;
      vid_data_q <= 8'h00;
      cpu_dout_q <= 8'h00;
      dio_ack_q  <= 1'b0;
      vid_ack_q  <= 1'b0;
      cpu_ack_q  <= 1'b0;
    end else begin
      dio_ack_q <= 1'b0;
      vid_ack_q <= 1'b0;
      cpu_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          grant_q <= grant_d;
          if (grant_d != 2'd0) state_q <= ISSUE;
        end
        ISSUE: begin
          ram_addr_q <= (grant_q == G_DIO) ? dio_addr : (grant_q == G_VID) ? vid_addr : cpu_addr;
          ram_din_q  <= (grant_q == G_DIO) ? dio_data : (grant_q == G_CPU) ? cpu_din : 8'h00;
          ram_we_q   <= (grant_q == G_DIO) || (grant_q == G_CPU && cpu_we);
          ram_oe_q   <= 1'b1;
          cnt_q      <= 3'd0;
          state_q    <= WAIT;
        end
        WAIT: begin
          if (cnt_q == WAIT_LAST) state_q <= DONE;
          else cnt_q <= cnt_q + 3'd1;
        end
        DONE: begin
          if (grant_q == G_VID) vid_data_q <= ram_dout;
          if (grant_q == G_CPU && !ram_we_q) cpu_dout_q <= ram_dout;
          dio_ack_q <= grant_q == G_DIO;
          vid_ack_q <= grant_q == G_VID;
          cpu_ack_q <= grant_q == G_CPU;
          ram_we_q  <= 1'b0;
          ram_oe_q  <= 1'b0;
          cnt_q     <= 3'd0;
          grant_q   <= 2'd0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign dio_ack    = dio_ack_q;
  assign vid_ack    = vid_ack_q;
  assign cpu_ack    = cpu_ack_q;
  assign vid_data   = vid_data_q;
  assign cpu_dout   = cpu_dout_q;
  assign ram_addr   = ram_addr_q;
  assign ram_din    = ram_din_q;
  assign ram_we     = ram_we_q;
  assign ram_oe     = ram_oe_q;
  assign grant      = grant_q;
  assign cpu_wait_n = !(cpu_req && !cpu_ack_q);
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and randomized checks of ram_arbiter against a transaction-level model
module tb_ram_arbiter;
  localparam int ADDR_W  = 25;
  localparam int RAM_LAT = 3;
  localparam int ACC     = RAM_LAT + 2;
  logic              F14M = 1'b0, RESET_n = 1'b0;
  logic              dio_req = 1'b0, vid_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0] dio_addr = '0, vid_addr = '0, cpu_addr = '0, ram_addr;
  logic [7:0]        dio_data = 8'h00, cpu_din = 8'h00, vid_data, cpu_dout, ram_din, ram_dout;
  logic              dio_ack, vid_ack, cpu_ack, cpu_wait_n, ram_we, ram_oe;
  logic [1:0]        grant;
  int total = 0, bad = 0;
  logic [7:0] ram_mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] exp_vid = 8'h00, exp_cpu = 8'h00;
  bit         rr_vid = 1'b1;
  logic       pre_we = 1'b0;
  logic [7:0] pre_idx = 8'h00, pre_val = 8'h00;
  int         oe_cnt = 0;

  ram_arbiter #(.ADDR_W(ADDR_W), .RAM_LAT(RAM_LAT)) dut (
    .F14M(F14M), .RESET_n(RESET_n),
    .dio_req(dio_req), .dio_addr(dio_addr), .dio_data(dio_data), .dio_ack(dio_ack),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_ack(vid_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .cpu_wait_n(cpu_wait_n),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_oe(ram_oe),
    .ram_dout(ram_dout), .grant(grant)
  );

  always #5 F14M = ~F14M;

  // SDRAM model: data only valid on the cycle RAM_LAT after ram_oe rises, junk otherwise
  always @(posedge F14M) begin
    if (pre_we) ram_mem[pre_idx] <= pre_val;
    else if (ram_oe && ram_we && oe_cnt == RAM_LAT - 1) ram_mem[ram_addr[7:0]] <= ram_din;
    oe_cnt <= ram_oe ? oe_cnt + 1 : 0;
  end
  assign ram_dout = (ram_oe && oe_cnt == RAM_LAT - 1) ? ram_mem[ram_addr[7:0]] : 8'hEE;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge F14M);
    #1;
  endtask

  task automatic setmem(input logic [7:0] idx, input logic [7:0] val);
    pre_we = 1'b1; pre_idx = idx; pre_val = val;
    tick();
    pre_we = 1'b0;
    ref_mem[idx] = val;
  endtask

  task automatic init_mem;
    for (int i = 0; i < 256; i++) setmem(8'(i), 8'($urandom));
  endtask

  task automatic do_reset;
    dio_req = 1'b0; vid_req = 1'b0; cpu_req = 1'b0;
    RESET_n = 1'b0;
    tick();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_acks", {dio_ack, vid_ack, cpu_ack}, 0);
    chk("rst_we_oe", {ram_we, ram_oe}, 0);
    chk("rst_addr", 32'(ram_addr), 0);
    chk("rst_din", 32'(ram_din), 0);
    chk("rst_rdata", {vid_data, cpu_dout}, 0);
    RESET_n = 1'b1;
    tick();
    exp_vid = 8'h00; exp_cpu = 8'h00; rr_vid = 1'b1;
  endtask

  // Raise the requesters in en (bit0 dio, bit1 vid, bit2 cpu) together, drop each on its ack.
  // Model: pending requests are served one per access of ACC cycles in priority order.
  task automatic do_round(input logic [2:0] en, input logic [ADDR_W-1:0] a_d, a_v, a_c,
                          input logic [7:0] d_d, d_c, input logic we_c);
    int got [3];
    int expc [3];
    logic [2:0] pend;
    int pos, w, wn_bad;
    pend = en; pos = 0; wn_bad = 0;
    for (int i = 0; i < 3; i++) begin got[i] = -1; expc[i] = -1; end
    while (pend != 3'b000) begin
      if (pend[0]) w = 0;
      else if (pend[1] && pend[2]) begin
`ifdef ARB_ROUNDROBIN_EN
        w = rr_vid ? 1 : 2;
`else
        w = 1;
`endif
      end else w = pend[1] ? 1 : 2;
      if (w != 0) rr_vid = !rr_vid;
      pos++;
      expc[w] = pos * ACC;
      pend[w] = 1'b0;
      if (w == 0) ref_mem[a_d[7:0]] = d_d;
      else if (w == 1) exp_vid = ref_mem[a_v[7:0]];
      else if (we_c) ref_mem[a_c[7:0]] = d_c;
      else exp_cpu = ref_mem[a_c[7:0]];
    end
    dio_addr = a_d; dio_data = d_d; vid_addr = a_v;
    cpu_addr = a_c; cpu_din = d_c; cpu_we = we_c;
    dio_req = en[0]; vid_req = en[1]; cpu_req = en[2];
    for (int k = 1; k <= 3 * ACC + 3; k++) begin
      tick();
      if (cpu_wait_n !== !(cpu_req && !cpu_ack)) wn_bad++;
      if (dio_ack) begin if (got[0] == -1) begin got[0] = k; dio_req = 1'b0; end else got[0] = -2; end
      if (vid_ack) begin if (got[1] == -1) begin got[1] = k; vid_req = 1'b0; end else got[1] = -2; end
      if (cpu_ack) begin if (got[2] == -1) begin got[2] = k; cpu_req = 1'b0; end else got[2] = -2; end
    end
    chk("rnd_dio_ack_cycle", got[0], expc[0]);
    chk("rnd_vid_ack_cycle", got[1], expc[1]);
    chk("rnd_cpu_ack_cycle", got[2], expc[2]);
    chk("rnd_vid_data", 32'(vid_data), 32'(exp_vid));
    chk("rnd_cpu_dout", 32'(cpu_dout), 32'(exp_cpu));
    chk("rnd_wait_n", wn_bad, 0);
  endtask

  initial begin
    int ack_t, ack2_t, oe_n, wlow, nv, nc, first;
    do_reset();
    init_mem();
    chk("idle_wait_n", 32'(cpu_wait_n), 1);

    // CPU read 0x00C000 returning 0x5A
    setmem(8'h00, 8'h5A);
    cpu_addr = 25'h00C000; cpu_we = 1'b0; cpu_req = 1'b1;
    #1;
    chk("cpu_rd_wait_low", 32'(cpu_wait_n), 0);
    ack_t = -1; oe_n = 0; wlow = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (ram_oe) oe_n++;
      if (k == 2) chk("cpu_rd_addr", 32'(ram_addr), 32'h00C000);
      if (k == 2) chk("cpu_rd_we", 32'(ram_we), 0);
      if (cpu_ack && ack_t < 0) begin ack_t = k; cpu_req = 1'b0; end
      else if (ack_t < 0 && cpu_wait_n === 1'b0) wlow++;
    end
    chk("cpu_rd_ack_cycle", ack_t, RAM_LAT + 2);
    chk("cpu_rd_oe_cycles", oe_n, RAM_LAT);
    chk("cpu_rd_wait_cycles", wlow, RAM_LAT + 1);
    chk("cpu_rd_data", 32'(cpu_dout), 32'h5A);
    chk("cpu_rd_wait_rel", 32'(cpu_wait_n), 1);

    // dio write and cpu read of the same byte raised on the same edge
    do_reset();
    setmem(8'h10, 8'h3C);
    dio_addr = 25'h000010; dio_data = 8'hA5; cpu_addr = 25'h000010; cpu_we = 1'b0;
    dio_req = 1'b1; cpu_req = 1'b1;
    ack_t = -1; ack2_t = -1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 1) chk("both_grant", 32'(grant), 1);
      if (k == 2) chk("both_ram_cmd", {ram_we, ram_oe, ram_din}, {2'b11, 8'hA5});
      if (k == 2) chk("both_ram_addr", 32'(ram_addr), 32'h10);
      if (dio_ack && ack_t < 0) begin ack_t = k; dio_req = 1'b0; end
      if (cpu_ack && ack2_t < 0) begin ack2_t = k; cpu_req = 1'b0; end
    end
    chk("both_dio_ack", ack_t, ACC);
    chk("both_cpu_ack", ack2_t, 2 * ACC);
    chk("both_cpu_data", 32'(cpu_dout), 32'hA5);

    // vid and cpu held continuously
    do_reset();
    vid_addr = 25'h000001; cpu_addr = 25'h000002; cpu_we = 1'b0;
    vid_req = 1'b1; cpu_req = 1'b1;
    nv = 0; nc = 0; wlow = 0; first = 0;
    for (int k = 1; k <= 6 * ACC; k++) begin
      tick();
      if (vid_ack) begin nv++; if (first == 0) first = 1; end
      if (cpu_ack) begin nc++; if (first == 0) first = 2; end
      if (cpu_wait_n === 1'b0) wlow++;
    end
    vid_req = 1'b0; cpu_req = 1'b0;
    tick();
`ifdef ARB_ROUNDROBIN_EN
    chk("hold_vid_acks", nv, 3);
    chk("hold_cpu_acks", nc, 3);
    chk("hold_wait_low", wlow, 6 * ACC - 3);
`else
    chk("hold_vid_acks", nv, 6);
    chk("hold_cpu_acks", nc, 0);
    chk("hold_wait_low", wlow, 6 * ACC);
`endif
    chk("hold_first", first, 1);

    // reset in the middle of a cpu write
    do_reset();
    setmem(8'h20, 8'h11);
    cpu_addr = 25'h000020; cpu_din = 8'h99; cpu_we = 1'b1; cpu_req = 1'b1;
    nc = 0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (cpu_ack) nc++;
    end
    chk("abort_in_wait_oe", 32'(ram_oe), 1);
    RESET_n = 1'b0;
    #1;
    chk("abort_grant", 32'(grant), 0);
    chk("abort_we_oe", {ram_we, ram_oe}, 0);
    for (int k = 1; k <= 2; k++) begin
      tick();
      if (cpu_ack) nc++;
    end
    chk("abort_no_ack", nc, 0);
    RESET_n = 1'b1; rr_vid = 1'b1;
    ack_t = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (cpu_ack && ack_t < 0) begin ack_t = k; cpu_req = 1'b0; end
    end
    chk("abort_reserve_ack", ack_t, ACC);
    chk("abort_reserve_mem", 32'(ram_mem[8'h20]), 32'h99);
    chk("abort_cpu_dout", 32'(cpu_dout), 0);

    // cpu read, cpu write 0x33, then vid read of 0x77
    do_reset();
    init_mem();
    setmem(8'h44, 8'h77);
    do_round(3'b100, '0, '0, 25'h1A0005, 8'h00, 8'h00, 1'b0);
    do_round(3'b100, '0, '0, 25'h000012, 8'h00, 8'h33, 1'b1);
    do_round(3'b010, '0, 25'h000044, '0, 8'h00, 8'h00, 1'b0);
    chk("wr_then_rd_vid", 32'(vid_data), 32'h77);

    // randomized mixes of simultaneous requests
    for (int r = 0; r < 40; r++)
      do_round(3'($urandom_range(1, 7)), ADDR_W'($urandom), ADDR_W'($urandom), ADDR_W'($urandom),
               8'($urandom), 8'($urandom), 1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
